// File: rtl/pkt_dsc_tracker.sv
// pkt_dsc_tracker: tracks one "descriptor outstanding" bit per queue and
// decides, for every incoming packet or descriptor-only request, whether a
// new descriptor is needed and whether its metadata should be dropped.
// Decisions leave in order through a small output FIFO.
// Optional statistics counters are built when PKT_DSC_TRACKER_STATS_EN is
// defined; otherwise the counter outputs are tied to zero.
module pkt_dsc_tracker #(
    parameter int NB_QUEUES      = 512,
    parameter int META_WIDTH     = 128,
    parameter int PTR_WIDTH      = 16,
    parameter int RD_LATENCY     = 2,
    parameter int OUT_FIFO_DEPTH = 8,
    localparam int QW            = $clog2(NB_QUEUES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [QW-1:0]         in_queue_id,
    input  logic [PTR_WIDTH-1:0]  in_head,
    input  logic [PTR_WIDTH-1:0]  in_tail,
    input  logic                  in_dsc_only,
    input  logic                  in_force_dsc,
    input  logic                  in_drop,
    input  logic [META_WIDTH-1:0] in_meta,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [QW-1:0]         out_queue_id,
    output logic [META_WIDTH-1:0] out_meta,
    output logic                  out_needs_dsc,
    output logic                  out_drop_meta,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           dsc_cnt,
    output logic [31:0]           suppressed_cnt,
    output logic [31:0]           drop_cnt,
    output logic                  init_busy
);
    localparam int FW = $clog2(OUT_FIFO_DEPTH);
    localparam int EW = QW + META_WIDTH + 2;

    logic                  init_busy_reg;
    logic [QW-1:0]         init_addr_reg;
    logic                  accept;

    logic                  p_valid_reg [1:RD_LATENCY];
    logic [QW-1:0]         p_qid_reg   [1:RD_LATENCY];
    logic [META_WIDTH-1:0] p_meta_reg  [1:RD_LATENCY];
    logic                  p_force_reg [1:RD_LATENCY];
    logic                  p_dsco_reg  [1:RD_LATENCY];
    logic                  p_empty_reg [1:RD_LATENCY];
    logic                  p_drop_reg  [1:RD_LATENCY];

    logic                  status_mem  [NB_QUEUES];
    logic                  rd_data_reg [1:RD_LATENCY];

    logic                  h_valid_reg [1:RD_LATENCY];
    logic [QW-1:0]         h_qid_reg   [1:RD_LATENCY];
    logic                  h_s_reg     [1:RD_LATENCY];
    logic [RD_LATENCY:1]   fwd_hit;

    logic                  s_old, s_new, needs_dsc, drop_meta;
    logic                  ram_we, ram_wdata;
    logic [QW-1:0]         ram_waddr;

    logic                  dec_valid_reg;
    logic [EW-1:0]         dec_entry_reg;

    logic [EW-1:0]         fifo_mem [OUT_FIFO_DEPTH];
    logic [FW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [FW:0]           count_reg;
    logic                  push, pop;
    int                    inflight;

    localparam int L = RD_LATENCY;

    // Status sweep after reset: clear one address per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_busy_reg <= 1'b1;
            init_addr_reg <= '0;
        end else if (init_busy_reg) begin
            init_addr_reg <= init_addr_reg + QW'(1);
            if (init_addr_reg == QW'(NB_QUEUES - 1))
                init_busy_reg <= 1'b0;
        end
    end

    assign init_busy = init_busy_reg;
    assign accept    = in_valid && in_ready;

    // Request pipeline that runs alongside the status-memory read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= L; k++) begin
                p_valid_reg[k] <= 1'b0;
                p_qid_reg[k]   <= '0;
                p_meta_reg[k]  <= '0;
                p_force_reg[k] <= 1'b0;
                p_dsco_reg[k]  <= 1'b0;
                p_empty_reg[k] <= 1'b0;
                p_drop_reg[k]  <= 1'b0;
            end
        end else begin
            p_valid_reg[1] <= accept;
            p_qid_reg[1]   <= in_queue_id;
            p_meta_reg[1]  <= in_meta;
            p_force_reg[1] <= in_force_dsc;
            p_dsco_reg[1]  <= in_dsc_only;
            p_empty_reg[1] <= (in_head == in_tail);
            p_drop_reg[1]  <= in_drop;
            for (int k = 2; k <= L; k++) begin
                p_valid_reg[k] <= p_valid_reg[k-1];
                p_qid_reg[k]   <= p_qid_reg[k-1];
                p_meta_reg[k]  <= p_meta_reg[k-1];
                p_force_reg[k] <= p_force_reg[k-1];
                p_dsco_reg[k]  <= p_dsco_reg[k-1];
                p_empty_reg[k] <= p_empty_reg[k-1];
                p_drop_reg[k]  <= p_drop_reg[k-1];
            end
        end
    end

    // Status read; a same-cycle write to the same address wins.
    always_ff @(posedge clk) begin
        if (ram_we && (ram_waddr == in_queue_id))
            rd_data_reg[1] <= ram_wdata;
        else
            rd_data_reg[1] <= status_mem[in_queue_id];
        for (int k = 2; k <= L; k++)
            rd_data_reg[k] <= rd_data_reg[k-1];
    end

    // Status write port, shared between the sweep and live decisions.
    always_ff @(posedge clk) begin
        if (ram_we)
            status_mem[ram_waddr] <= ram_wdata;
    end

    // Decisions made in the last L cycles were written after this request
    // read the memory, so they must be forwarded.
    genvar gi;
    generate
        for (gi = 1; gi <= RD_LATENCY; gi++) begin : g_fwd
            assign fwd_hit[gi] = h_valid_reg[gi] && (h_qid_reg[gi] == p_qid_reg[L]);
        end
    endgenerate

    // Old-status selection (youngest forwarded decision wins) and decision.
    always_comb begin
        s_old = rd_data_reg[L];
        for (int k = L; k >= 1; k--)
            if (fwd_hit[k]) s_old = h_s_reg[k];
        needs_dsc = 1'b0;
        drop_meta = 1'b0;
        s_new     = s_old;
        if (p_force_reg[L]) begin
            needs_dsc = 1'b1;
            s_new     = 1'b1;
        end else if (p_dsco_reg[L]) begin
            if (p_empty_reg[L]) begin
                drop_meta = 1'b1;
                s_new     = 1'b0;
            end else begin
                needs_dsc = 1'b1;
                s_new     = 1'b1;
            end
        end else if (p_drop_reg[L]) begin
            drop_meta = 1'b1;
        end else begin
            needs_dsc = !s_old;
            s_new     = 1'b1;
        end
    end

    // Write-port mux: sweep has the port exclusively while it runs.
    always_comb begin
        ram_we    = init_busy_reg || p_valid_reg[L];
        ram_waddr = init_busy_reg ? init_addr_reg : p_qid_reg[L];
        ram_wdata = init_busy_reg ? 1'b0 : s_new;
    end

    // Decision history for forwarding, plus the registered decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= L; k++) begin
                h_valid_reg[k] <= 1'b0;
                h_qid_reg[k]   <= '0;
                h_s_reg[k]     <= 1'b0;
            end
            dec_valid_reg <= 1'b0;
            dec_entry_reg <= '0;
        end else begin
            h_valid_reg[1] <= p_valid_reg[L];
            h_qid_reg[1]   <= p_qid_reg[L];
            h_s_reg[1]     <= s_new;
            for (int k = 2; k <= L; k++) begin
                h_valid_reg[k] <= h_valid_reg[k-1];
                h_qid_reg[k]   <= h_qid_reg[k-1];
                h_s_reg[k]     <= h_s_reg[k-1];
            end
            dec_valid_reg <= p_valid_reg[L];
            dec_entry_reg <= {p_qid_reg[L], p_meta_reg[L], needs_dsc, drop_meta};
        end
    end

    assign push = dec_valid_reg;
    assign pop  = out_valid && out_ready;

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= dec_entry_reg;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + FW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + FW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (FW+1)'(1);
                2'b01:   count_reg <= count_reg - (FW+1)'(1);
                default: ;
            endcase
        end
    end

    assign out_valid = (count_reg != '0);
    assign {out_queue_id, out_meta, out_needs_dsc, out_drop_meta} = fifo_mem[rd_ptr_reg];

    // Reserve a FIFO slot for every request already in flight.
    always_comb begin
        inflight = dec_valid_reg ? 1 : 0;
        for (int k = 1; k <= L; k++)
            if (p_valid_reg[k]) inflight++;
    end

    assign in_ready = !init_busy_reg && ((int'(count_reg) + inflight) < OUT_FIFO_DEPTH);

`ifdef PKT_DSC_TRACKER_STATS_EN
    logic [31:0] dsc_cnt_reg, sup_cnt_reg, drop_cnt_reg;

    // Statistics on popped entries; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dsc_cnt_reg  <= '0;
            sup_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else if (pop) begin
            if (out_needs_dsc)                   dsc_cnt_reg  <= dsc_cnt_reg + 32'd1;
            if (!out_needs_dsc && !out_drop_meta) sup_cnt_reg  <= sup_cnt_reg + 32'd1;
            if (out_drop_meta)                   drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end

    assign dsc_cnt        = dsc_cnt_reg;
    assign suppressed_cnt = sup_cnt_reg;
    assign drop_cnt       = drop_cnt_reg;
`else
    assign dsc_cnt        = '0;
    assign suppressed_cnt = '0;
    assign drop_cnt       = '0;
`endif

endmodule

// File: tb/tb_pkt_dsc_tracker.sv
// Self-checking bench for pkt_dsc_tracker: scoreboard of expected decisions
// built from a per-queue status model, popped as the DUT emits entries.
module tb_pkt_dsc_tracker;
    localparam int NBQ = 512;
    localparam int MW  = 128;
    localparam int PW  = 16;
    localparam int RL  = 2;
    localparam int FD  = 8;
    localparam int QW  = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [QW-1:0] in_queue_id = '0;
    logic [PW-1:0] in_head = '0, in_tail = '0;
    logic          in_dsc_only = 1'b0, in_force_dsc = 1'b0, in_drop = 1'b0;
    logic [MW-1:0] in_meta = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [QW-1:0] out_queue_id;
    logic [MW-1:0] out_meta;
    logic          out_needs_dsc, out_drop_meta, out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   dsc_cnt, suppressed_cnt, drop_cnt;
    logic          init_busy;

    pkt_dsc_tracker #(
        .NB_QUEUES(NBQ), .META_WIDTH(MW), .PTR_WIDTH(PW),
        .RD_LATENCY(RL), .OUT_FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .in_queue_id(in_queue_id), .in_head(in_head), .in_tail(in_tail),
        .in_dsc_only(in_dsc_only), .in_force_dsc(in_force_dsc), .in_drop(in_drop),
        .in_meta(in_meta), .in_valid(in_valid), .in_ready(in_ready),
        .out_queue_id(out_queue_id), .out_meta(out_meta),
        .out_needs_dsc(out_needs_dsc), .out_drop_meta(out_drop_meta),
        .out_valid(out_valid), .out_ready(out_ready),
        .dsc_cnt(dsc_cnt), .suppressed_cnt(suppressed_cnt), .drop_cnt(drop_cnt),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [QW-1:0] qid;
        logic [MW-1:0] meta;
        logic          needs;
        logic          dm;
    } exp_t;

    exp_t sb[$];
    bit   model_s [NBQ];
    int   total = 0;
    int   bad = 0;
    int   cyc_cnt = 0;
    int   ex_dsc = 0, ex_sup = 0, ex_drop = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Reference decision for one accepted request; updates the status model.
    function automatic exp_t model_step(input int q, input int hd, input int tl,
                                        input bit dsco, input bit frc, input bit drp,
                                        input logic [MW-1:0] meta);
        exp_t e;
        bit s;
        s = model_s[q];
        e.qid = QW'(q);
        e.meta = meta;
        e.needs = 1'b0;
        e.dm = 1'b0;
        if (frc) begin
            e.needs = 1'b1; model_s[q] = 1'b1;
        end else if (dsco && hd == tl) begin
            e.dm = 1'b1; model_s[q] = 1'b0;
        end else if (dsco) begin
            e.needs = 1'b1; model_s[q] = 1'b1;
        end else if (drp) begin
            e.dm = 1'b1;
        end else begin
            e.needs = !s; model_s[q] = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NBQ; i++) model_s[i] = 1'b0;
        sb.delete();
        ex_dsc = 0; ex_sup = 0; ex_drop = 0;
    endfunction

    task automatic drive(input int q, input int hd, input int tl,
                         input bit dsco, input bit frc, input bit drp);
        in_queue_id  = QW'(q);
        in_head      = PW'(hd);
        in_tail      = PW'(tl);
        in_dsc_only  = dsco;
        in_force_dsc = frc;
        in_drop      = drp;
        in_meta      = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid     = 1'b1;
    endtask

    // Present one request at a negedge, wait for acceptance, record expectation.
    task automatic send(input int q, input int hd, input int tl,
                        input bit dsco, input bit frc, input bit drp, output int acc_cyc);
        int g;
        drive(q, hd, tl, dsco, frc, drp);
        g = 0;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_ready q=%0d in_ready=%b required 1", q, in_ready);
            acc_cyc = -1;
            @(negedge clk);
            return;
        end
        acc_cyc = cyc_cnt;
        sb.push_back(model_step(q, hd, tl, dsco, frc, drp, in_meta));
        @(negedge clk);
    endtask

    task automatic apply_reset();
        int n;
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (init_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (init_busy) begin
            total++; bad++;
            $display("FAIL reset_sweep_timeout init_busy=%b required 0", init_busy);
        end
        model_clear();
    endtask

    task automatic test_reset();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (init_busy !== 1'b1) begin bad++; $display("FAIL rst_init_busy got=%b required 1", init_busy); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b required 0", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b required 0", out_valid); end
        rst = 1'b1;
        n = 0;
        while (init_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== NBQ) begin bad++; $display("FAIL init_busy_cycles got=%0d required %0d", n, NBQ); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_init got=%b required 1", in_ready); end
        total++;
        if (dsc_cnt !== 32'd0 || suppressed_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_counters got=%0d/%0d/%0d required 0/0/0", dsc_cnt, suppressed_cnt, drop_cnt);
        end
        model_clear();
        $display("test_reset: init sweep cycles=%0d", n);
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2, got, cyc, first_cyc;
        logic [2:0] needs_seq;
        exp_t e;
        apply_reset();
        out_ready = 1'b1;
        send(5, 0, 0, 1'b0, 1'b0, 1'b0, a0);
        send(5, 0, 0, 1'b0, 1'b0, 1'b0, a1);
        send(5, 0, 0, 1'b0, 1'b0, 1'b0, a2);
        in_valid = 1'b0;
        total++;
        if (a1 != a0 + 1 || a2 != a0 + 2) begin
            bad++; $display("FAIL b2b_accept_cycles got=%0d,%0d,%0d required consecutive", a0, a1, a2);
        end
        got = 0; cyc = 0; first_cyc = -1; needs_seq = '0;
        while (got < 3 && cyc < 100) begin
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc_cnt;
                e = sb.pop_front();
                needs_seq[2-got] = out_needs_dsc;
                total++;
                if (out_queue_id !== e.qid || out_meta !== e.meta || out_needs_dsc !== e.needs || out_drop_meta !== e.dm) begin
                    bad++;
                    $display("FAIL b2b_entry%0d got q=%0d needs=%b drop=%b required q=%0d needs=%b drop=%b", got, out_queue_id, out_needs_dsc, out_drop_meta, e.qid, e.needs, e.dm);
                end
                ex_dsc += e.needs ? 1 : 0; ex_sup += (!e.needs && !e.dm) ? 1 : 0; ex_drop += e.dm ? 1 : 0;
                $display("b2b: entry q=%0d needs=%b drop=%b", out_queue_id, out_needs_dsc, out_drop_meta);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got != 3) begin bad++; $display("FAIL b2b_count got=%0d required 3", got); end
        total++;
        if (needs_seq !== 3'b100) begin bad++; $display("FAIL b2b_needs_seq got=%b required 100", needs_seq); end
        total++;
        if (first_cyc != a0 + RL + 2) begin
            bad++; $display("FAIL b2b_latency got=%0d required %0d", first_cyc - a0, RL + 2);
        end
`ifdef PKT_DSC_TRACKER_STATS_EN
        total++;
        if (dsc_cnt !== 32'd1 || suppressed_cnt !== 32'd2 || drop_cnt !== 32'd0) begin
            bad++; $display("FAIL b2b_stats got=%0d/%0d/%0d required 1/2/0", dsc_cnt, suppressed_cnt, drop_cnt);
        end
`else
        total++;
        if (dsc_cnt !== 32'd0 || suppressed_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
            bad++; $display("FAIL b2b_stats_off got=%0d/%0d/%0d required 0/0/0", dsc_cnt, suppressed_cnt, drop_cnt);
        end
`endif
    endtask

    task automatic test_dsc_only();
        int a, got, cyc;
        logic [2:0] needs_seq, drop_seq;
        exp_t e;
        apply_reset();
        out_ready = 1'b1;
        send(5, 0, 0, 1'b0, 1'b0, 1'b0, a);
        send(5, 40, 40, 1'b1, 1'b0, 1'b0, a);
        send(5, 0, 0, 1'b0, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        got = 0; cyc = 0; needs_seq = '0; drop_seq = '0;
        while (got < 3 && cyc < 100) begin
            if (out_valid) begin
                e = sb.pop_front();
                needs_seq[2-got] = out_needs_dsc;
                drop_seq[2-got] = out_drop_meta;
                total++;
                if (out_queue_id !== e.qid || out_meta !== e.meta || out_needs_dsc !== e.needs || out_drop_meta !== e.dm) begin
                    bad++;
                    $display("FAIL dsco_entry%0d got q=%0d needs=%b drop=%b required q=%0d needs=%b drop=%b", got, out_queue_id, out_needs_dsc, out_drop_meta, e.qid, e.needs, e.dm);
                end
                ex_dsc += e.needs ? 1 : 0; ex_sup += (!e.needs && !e.dm) ? 1 : 0; ex_drop += e.dm ? 1 : 0;
                $display("dsc_only: entry q=%0d needs=%b drop=%b", out_queue_id, out_needs_dsc, out_drop_meta);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got != 3) begin bad++; $display("FAIL dsco_count got=%0d required 3", got); end
        total++;
        if (needs_seq !== 3'b101 || drop_seq !== 3'b010) begin
            bad++; $display("FAIL dsco_seq got needs=%b drop=%b required needs=101 drop=010", needs_seq, drop_seq);
        end
    endtask

    task automatic test_drop();
        int a, got, cyc;
        logic [1:0] needs_seq, drop_seq;
        exp_t e;
        apply_reset();
        out_ready = 1'b1;
        send(7, 0, 0, 1'b0, 1'b0, 1'b1, a);
        send(7, 0, 0, 1'b0, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        got = 0; cyc = 0; needs_seq = '0; drop_seq = '0;
        while (got < 2 && cyc < 100) begin
            if (out_valid) begin
                e = sb.pop_front();
                needs_seq[1-got] = out_needs_dsc;
                drop_seq[1-got] = out_drop_meta;
                total++;
                if (out_queue_id !== e.qid || out_meta !== e.meta || out_needs_dsc !== e.needs || out_drop_meta !== e.dm) begin
                    bad++;
                    $display("FAIL drop_entry%0d got q=%0d needs=%b drop=%b required q=%0d needs=%b drop=%b", got, out_queue_id, out_needs_dsc, out_drop_meta, e.qid, e.needs, e.dm);
                end
                ex_dsc += e.needs ? 1 : 0; ex_sup += (!e.needs && !e.dm) ? 1 : 0; ex_drop += e.dm ? 1 : 0;
                $display("drop: entry q=%0d needs=%b drop=%b", out_queue_id, out_needs_dsc, out_drop_meta);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got != 2) begin bad++; $display("FAIL drop_count got=%0d required 2", got); end
        total++;
        if (needs_seq !== 2'b01 || drop_seq !== 2'b10) begin
            bad++; $display("FAIL drop_seq got needs=%b drop=%b required needs=01 drop=10", needs_seq, drop_seq);
        end
    endtask

    task automatic test_backpressure();
        int acc, got, cyc, q;
        bit held;
        logic [MW-1:0] held_meta;
        logic [QW-1:0] held_q;
        exp_t e;
        out_ready = 1'b0;
        acc = 0; held = 1'b0; held_meta = '0; held_q = '0;
        for (int i = 0; i < 24; i++) begin
            q = 10 + (i % 3);
            drive(q, 0, 0, 1'b0, 1'b0, (i % 5) == 4);
            if (in_ready) begin
                sb.push_back(model_step(q, 0, 0, 1'b0, 1'b0, (i % 5) == 4, in_meta));
                acc++;
            end
            if (out_valid && !held) begin
                held = 1'b1; held_meta = out_meta; held_q = out_queue_id;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (acc != FD) begin bad++; $display("FAIL bp_accepted got=%0d required %0d", acc, FD); end
        total++;
        if (!held || out_valid !== 1'b1 || out_meta !== held_meta || out_queue_id !== held_q) begin
            bad++; $display("FAIL bp_hold got valid=%b q=%0d required valid=1 q=%0d stable", out_valid, out_queue_id, held_q);
        end
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < FD && cyc < 100) begin
            if (out_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL bp_extra got q=%0d required none", out_queue_id);
                end else begin
                    e = sb.pop_front();
                    if (out_queue_id !== e.qid || out_meta !== e.meta || out_needs_dsc !== e.needs || out_drop_meta !== e.dm) begin
                        bad++;
                        $display("FAIL bp_entry%0d got q=%0d needs=%b drop=%b required q=%0d needs=%b drop=%b", got, out_queue_id, out_needs_dsc, out_drop_meta, e.qid, e.needs, e.dm);
                    end
                    ex_dsc += e.needs ? 1 : 0; ex_sup += (!e.needs && !e.dm) ? 1 : 0; ex_drop += e.dm ? 1 : 0;
                end
                $display("backpressure: entry q=%0d needs=%b drop=%b", out_queue_id, out_needs_dsc, out_drop_meta);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got != FD) begin bad++; $display("FAIL bp_drain got=%0d required %0d", got, FD); end
        repeat (5) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad++; $display("FAIL bp_leftover got valid=%b pending=%0d required 0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_throughput();
        localparam int N = 30;
        int first_acc, last_acc, got, cyc;
        exp_t e;
        out_ready = 1'b1;
        first_acc = -1; last_acc = -1; got = 0;
        fork
            begin
                int a, q, r;
                for (int i = 0; i < N; i++) begin
                    q = 30 + (i % 5);
                    r = $urandom_range(0, 7);
                    send(q, $urandom_range(0, 2), $urandom_range(0, 2), r == 1 || r == 2, r == 3, r == 4, a);
                    if (i == 0) first_acc = a;
                    last_acc = a;
                end
                in_valid = 1'b0;
            end
            begin
                cyc = 0;
                while (got < N && cyc < 300) begin
                    if (out_valid) begin
                        total++;
                        if (sb.size() == 0) begin
                            bad++; $display("FAIL tp_extra got q=%0d required none", out_queue_id);
                        end else begin
                            e = sb.pop_front();
                            if (out_queue_id !== e.qid || out_meta !== e.meta || out_needs_dsc !== e.needs || out_drop_meta !== e.dm) begin
                                bad++;
                                $display("FAIL tp_entry%0d got q=%0d needs=%b drop=%b required q=%0d needs=%b drop=%b", got, out_queue_id, out_needs_dsc, out_drop_meta, e.qid, e.needs, e.dm);
                            end
                            ex_dsc += e.needs ? 1 : 0; ex_sup += (!e.needs && !e.dm) ? 1 : 0; ex_drop += e.dm ? 1 : 0;
                        end
                        $display("throughput: entry q=%0d needs=%b drop=%b", out_queue_id, out_needs_dsc, out_drop_meta);
                        got++;
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        total++;
        if (got != N) begin bad++; $display("FAIL tp_count got=%0d required %0d", got, N); end
        total++;
        if (last_acc - first_acc != N - 1) begin
            bad++; $display("FAIL tp_rate got span=%0d required %0d", last_acc - first_acc, N - 1);
        end
    endtask

    task automatic test_stats();
`ifdef PKT_DSC_TRACKER_STATS_EN
        total++;
        if (dsc_cnt !== 32'(ex_dsc) || suppressed_cnt !== 32'(ex_sup) || drop_cnt !== 32'(ex_drop)) begin
            bad++; $display("FAIL stats got=%0d/%0d/%0d required %0d/%0d/%0d", dsc_cnt, suppressed_cnt, drop_cnt, ex_dsc, ex_sup, ex_drop);
        end
`else
        total++;
        if (dsc_cnt !== 32'd0 || suppressed_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
            bad++; $display("FAIL stats_off got=%0d/%0d/%0d required 0/0/0", dsc_cnt, suppressed_cnt, drop_cnt);
        end
`endif
        $display("stats: dsc=%0d suppressed=%0d drop=%0d", dsc_cnt, suppressed_cnt, drop_cnt);
    endtask

    task automatic test_reset_mid();
        int a, n, got, cyc;
        exp_t e;
        out_ready = 1'b1;
        send(20, 0, 0, 1'b0, 1'b0, 1'b0, a);
        send(20, 0, 0, 1'b0, 1'b0, 1'b0, a);
        send(21, 0, 0, 1'b0, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || init_busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_rst_state got valid=%b busy=%b ready=%b required 0/1/0", out_valid, init_busy, in_ready);
        end
        rst = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (init_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== NBQ) begin bad++; $display("FAIL mid_sweep_cycles got=%0d required %0d", n, NBQ); end
        model_clear();
        send(20, 0, 0, 1'b0, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        got = 0; cyc = 0;
        while (cyc < 12) begin
            if (out_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL mid_extra got q=%0d required none", out_queue_id);
                end else begin
                    e = sb.pop_front();
                    if (out_queue_id !== e.qid || out_meta !== e.meta || out_needs_dsc !== e.needs || out_drop_meta !== e.dm) begin
                        bad++;
                        $display("FAIL mid_entry got q=%0d needs=%b drop=%b required q=%0d needs=%b drop=%b", out_queue_id, out_needs_dsc, out_drop_meta, e.qid, e.needs, e.dm);
                    end
                    ex_dsc += e.needs ? 1 : 0; ex_sup += (!e.needs && !e.dm) ? 1 : 0; ex_drop += e.dm ? 1 : 0;
                end
                $display("reset_mid: entry q=%0d needs=%b drop=%b", out_queue_id, out_needs_dsc, out_drop_meta);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got != 1) begin bad++; $display("FAIL mid_count got=%0d required 1", got); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_dsc_only();
        test_drop();
        test_backpressure();
        test_throughput();
        test_stats();
        test_reset_mid();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pkt_dsc_tracker.md
PKT_DSC_TRACKER -- requirements
Module: pkt_dsc_tracker

Interface
REQ-001 SHALL have parameter NB_QUEUES, default 512: number of tracked queues; power of two, >= 2.
REQ-002 SHALL have parameter META_WIDTH, default 128: width of the opaque pass-through metadata.
REQ-003 SHALL have parameter PTR_WIDTH, default 16: width of head and tail pointers.
REQ-004 SHALL have parameter RD_LATENCY, default 2: status-memory read latency in cycles; legal range 1..4.
REQ-005 SHALL have parameter OUT_FIFO_DEPTH, default 8: output FIFO entries; power of two, >= 4.
REQ-006 SHALL have these ports (QW = clog2(NB_QUEUES)): clk input 1 clock; rst input 1 asynchronous active-low reset.
- in_queue_id input QW; in_head, in_tail input PTR_WIDTH; in_dsc_only, in_force_dsc, in_drop input 1; in_meta input META_WIDTH; in_valid input 1; in_ready output 1.
- out_queue_id output QW; out_meta output META_WIDTH; out_needs_dsc, out_drop_meta, out_valid output 1; out_ready input 1.
- dsc_cnt, suppressed_cnt, drop_cnt output 32 each; init_busy output 1.

Function
REQ-007 SHALL hold one status bit per queue (1 = descriptor outstanding) in an inferred RAM with RD_LATENCY read latency.
REQ-008 SHALL accept an input on a cycle where in_valid and in_ready are both high; each accepted input yields exactly one FIFO entry, in order.
REQ-009 SHALL decide each input from its old status S, with the following priority:
- in_force_dsc: needs_dsc=1, drop_meta=0, new S=1.
- in_dsc_only with head==tail: needs_dsc=0, drop_meta=1, new S=0.
- in_dsc_only with head!=tail: needs_dsc=1, drop_meta=0, new S=1.
- packet with in_drop: needs_dsc=0, drop_meta=1, S unchanged.
- any other packet: needs_dsc=!S, drop_meta=0, new S=1.
REQ-010 SHALL forward S from the youngest in-flight or just-written decision to the same queue whenever that decision is not yet visible in the RAM; back-to-back same-queue inputs SHALL therefore behave as if processed serially.
REQ-011 SHALL resolve a RAM read and write to the same address in the same cycle to the written value.
REQ-012 SHALL write the decision into the FIFO exactly RD_LATENCY+1 cycles after acceptance; out_valid SHALL rise no earlier than one cycle later.
REQ-013 SHALL drive in_ready = !init_busy && (FIFO occupancy + in-flight count) < OUT_FIFO_DEPTH, so the FIFO never overflows.
REQ-014 SHALL present the FIFO head on the out_* ports and pop it on out_valid && out_ready; out_* SHALL hold stable while out_valid && !out_ready.
REQ-015 SHALL support full throughput: one input per cycle sustained while out_ready is high.

Reset
REQ-016 SHALL, while rst is low, clear out_valid, the FIFO, the pipeline, the forwarding state and the counters, and set init_busy=1 and in_ready=0.
REQ-017 SHALL, after rst deasserts, sweep every status address to 0 at one per cycle; init_busy SHALL drop after exactly NB_QUEUES cycles.
REQ-018 SHALL abandon any in-flight inputs and restart the sweep from address 0 when rst is asserted mid-operation or mid-sweep.

Configuration
REQ-019 SHALL compile the counters only when PKT_DSC_TRACKER_STATS_EN is defined:
- dsc_cnt increments on each popped entry with needs_dsc=1.
- suppressed_cnt increments on each popped non-drop packet with needs_dsc=0.
- drop_cnt increments on each popped entry with drop_meta=1.
- All three wrap modulo 2^32.
REQ-020 SHALL tie dsc_cnt, suppressed_cnt and drop_cnt to 0 when PKT_DSC_TRACKER_STATS_EN is undefined.

Verification
REQ-021 Reset, then count cycles -> init_busy stays high for exactly NB_QUEUES cycles; in_ready rises the following cycle.
REQ-022 Three back-to-back packets to queue 5, out_ready=1 -> needs_dsc = 1,0,0; first out_valid at acceptance+RD_LATENCY+2.
REQ-023 Packet q5, then dsc_only q5 with head=tail=40, then packet q5, all consecutive -> needs_dsc 1,0,1; the second entry has drop_meta=1.
REQ-024 out_ready=0 with continuous valid input -> exactly OUT_FIFO_DEPTH inputs accepted, none lost; release out_ready -> all emitted in order.
REQ-025 Dropped packet to q7 after reset, then normal packet q7 -> first entry needs_dsc=0 with drop_meta=1; second entry needs_dsc=1.
REQ-026 With PKT_DSC_TRACKER_STATS_EN defined, run REQ-022 -> dsc_cnt=1, suppressed_cnt=2, drop_cnt=0; with it undefined -> all three read 0.
